// File: rtl/up_frame_sched_pkg.sv
// Shared constants, FSM state type and frame-width helper for the uplink scheduler.
package up_frame_pkg;

  localparam logic [7:0]  HEAD_BASE_DEF = 8'hA1;
  localparam logic [7:0]  HEAD_VER_DEF  = 8'hA6;
  localparam logic [7:0]  HEAD_FLT_DEF  = 8'hA5;
  localparam logic [7:0]  HEAD_CLR_DEF  = 8'hA7;
  localparam logic [15:0] VER_DEF       = 16'h4011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_LOAD,
    ST_SEND,
    ST_NEXT,
    ST_FRAME_F
  } state_e;

  function automatic int unsigned frame_w(input int unsigned head_w, input int unsigned data_w);
    return head_w + data_w;
  endfunction

endpackage

// File: rtl/up_frame_sched_edge_sync.sv
// Three-flop synchroniser for an asynchronous level with single-cycle rise/fall pulses.
module up_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // Two metastability stages, third stage holds the previous synchronised value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], d_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/up_frame_sched.sv
// Upstream telemetry scheduler: snapshots N_CH channels per tick, sends {header,data}
// frames plus a version frame, and interleaves fault assert/clear frames at frame boundaries.
module up_frame_sched
  import up_frame_pkg::*;
#(
  parameter int unsigned       N_CH      = 4,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       HEAD_W    = 8,
  parameter logic [HEAD_W-1:0] HEAD_BASE = HEAD_W'(HEAD_BASE_DEF),
  parameter logic [HEAD_W-1:0] HEAD_VER  = HEAD_W'(HEAD_VER_DEF),
  parameter logic [HEAD_W-1:0] HEAD_FLT  = HEAD_W'(HEAD_FLT_DEF),
  parameter logic [HEAD_W-1:0] HEAD_CLR  = HEAD_W'(HEAD_CLR_DEF),
  parameter logic [15:0]       VER       = VER_DEF,
  parameter logic              SEND_VER  = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   fault,
  input  logic                                   tick,
  input  logic [N_CH-1:0]                        ch_en,
  input  logic [N_CH*DATA_W-1:0]                 ch_data,
  input  logic [DATA_W-1:0]                      state,
  input  logic                                   tx_done,
  output logic                                   tx_start,
  output logic [frame_w(HEAD_W, DATA_W)-1:0]     tx_data,
  output logic                                   busy,
  output logic [7:0]                             overrun
);

  localparam int unsigned FW    = frame_w(HEAD_W, DATA_W);
  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e              state_q, state_d;
  logic                tick_pend_q, tick_pend_d;
  logic                flt_pend_q, flt_pend_d;
  logic                clr_pend_q, clr_pend_d;
  logic                clr_first_q, clr_first_d;
  logic                scan_q, scan_d;
  logic                ver_pend_q, ver_pend_d;
  logic [N_CH-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   snap_q [N_CH];
  logic [DATA_W-1:0]   snap_d [N_CH];
  logic [FW-1:0]       tx_data_q, tx_data_d;
  logic [7:0]          overrun_q, overrun_d;
  logic                flt_rise, flt_fall;
  logic [IDX_W-1:0]    idx;
  logic [HEAD_W-1:0]   head_ch;

  up_edge_sync u_flt_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (fault),
    .rise_o (flt_rise),
    .fall_o (flt_fall)
  );

  // State, pending flags, snapshot and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_pend_q <= 1'b0;
      flt_pend_q  <= 1'b0;
      clr_pend_q  <= 1'b0;
      clr_first_q <= 1'b0;
      scan_q      <= 1'b0;
      ver_pend_q  <= 1'b0;
      rem_q       <= '0;
      tx_data_q   <= '0;
      overrun_q   <= '0;
      for (int unsigned i = 0; i < N_CH; i++) snap_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      tick_pend_q <= tick_pend_d;
      flt_pend_q  <= flt_pend_d;
      clr_pend_q  <= clr_pend_d;
      clr_first_q <= clr_first_d;
      scan_q      <= scan_d;
      ver_pend_q  <= ver_pend_d;
      rem_q       <= rem_d;
      tx_data_q   <= tx_data_d;
      overrun_q   <= overrun_d;
      snap_q      <= snap_d;
    end
  end

  // Next-state logic: edge/tick bookkeeping first, then the frame sequencer.
  // A scan is tracked as a mask of channels still to send plus a version flag,
  // so a fault frame can be slotted in at NEXT and the scan simply resumes.
  always_comb begin
    state_d     = state_q;
    tick_pend_d = tick_pend_q;
    flt_pend_d  = flt_pend_q;
    clr_pend_d  = clr_pend_q;
    clr_first_d = clr_first_q;
    scan_d      = scan_q;
    ver_pend_d  = ver_pend_q;
    rem_d       = rem_q;
    tx_data_d   = tx_data_q;
    overrun_d   = overrun_q;
    snap_d      = snap_q;

    idx = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (rem_q[i-1]) idx = IDX_W'(i - 1);
    end
    head_ch = HEAD_BASE + HEAD_W'(idx);

    if (flt_rise && !flt_pend_q) begin
      flt_pend_d  = 1'b1;
      clr_first_d = clr_pend_q;
    end
    if (flt_fall && !clr_pend_q) begin
      clr_pend_d  = 1'b1;
      clr_first_d = !flt_pend_q;
    end

    if (tick) begin
      if (tick_pend_q || scan_q) begin
        if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
      end else begin
        tick_pend_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (flt_pend_q || clr_pend_q) state_d = ST_FRAME_F;
        else if (tick_pend_q)         state_d = ST_SNAP;
      end
      ST_SNAP: begin
        for (int unsigned i = 0; i < N_CH; i++) snap_d[i] = ch_data[i*DATA_W +: DATA_W];
        rem_d       = ch_en;
        ver_pend_d  = SEND_VER;
        tick_pend_d = 1'b0;
        if (ch_en != '0 || SEND_VER) begin
          scan_d  = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (rem_q != '0) begin
          tx_data_d  = {head_ch, snap_q[idx]};
          rem_d[idx] = 1'b0;
        end else begin
          tx_data_d  = {HEAD_VER, DATA_W'(VER)};
          ver_pend_d = 1'b0;
        end
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (rem_q == '0 && !ver_pend_q) scan_d = 1'b0;
        if (flt_pend_q || clr_pend_q)           state_d = ST_FRAME_F;
        else if (rem_q != '0 || ver_pend_q)     state_d = ST_LOAD;
        else                                    state_d = ST_IDLE;
      end
      ST_FRAME_F: begin
        if (clr_pend_q && (!flt_pend_q || clr_first_q)) begin
          tx_data_d  = {HEAD_CLR, state};
          clr_pend_d = 1'b0;
        end else begin
          tx_data_d  = {HEAD_FLT, state};
          flt_pend_d = 1'b0;
        end
        state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_start = (state_q == ST_SEND);
  assign tx_data  = tx_data_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != ST_IDLE) | tick_pend_q | flt_pend_q | clr_pend_q;

endmodule
